multicycle_control_unit: RTL and testbench

Parametrised multicycle successor to the single-cycle control_unit of the ARM-subset processor.
- Decodes instruction[31:12] over several states instead of one cycle.
- Holds a NZCV flag register and evaluates condition codes against it.
- Stalls on a memory-ready handshake.
- Drives all datapath enables and mux selects for a shared-memory, multicycle datapath.

---
 rtl/mcu_pkg.sv | 77 +++++++
 rtl/cond_check.sv | 36 +++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared types, encodings and decode helpers for the multicycle control unit.
package mcu_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXECR,
      EXECI,
      ALUWB,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      BRANCH
   } state_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;
   localparam logic [3:0] CMD_MVN = 4'b1111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;
   localparam logic [3:0] ALU_EOR = 4'b0100;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   function automatic logic cmd_supported(input logic [3:0] cmd);
      return cmd inside {CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD, CMD_TST,
                         CMD_CMP, CMD_ORR, CMD_MOV, CMD_MVN};
   endfunction

   // Compare/test commands only touch the flags and skip write-back
   function automatic logic cmd_is_test(input logic [3:0] cmd);
      return (cmd == CMD_CMP) || (cmd == CMD_TST);
   endfunction

   function automatic logic [3:0] alu_op(input logic [3:0] cmd);
      case (cmd)
         CMD_AND, CMD_TST: return ALU_AND;
         CMD_EOR:          return ALU_EOR;
         CMD_SUB, CMD_CMP: return ALU_SUB;
         CMD_ORR:          return ALU_ORR;
         default:          return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against the stored NZCV flags.
module cond_check
   import mcu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ok
);

   logic n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = z;
         COND_NE: cond_ok = ~z;
         COND_CS: cond_ok = c;
         COND_CC: cond_ok = ~c;
         COND_MI: cond_ok = n;
         COND_PL: cond_ok = ~n;
         COND_VS: cond_ok = v;
         COND_VC: cond_ok = ~v;
         COND_HI: cond_ok = c & ~z;
         COND_LS: cond_ok = ~c | z;
         COND_GE: cond_ok = (n == v);
         COND_LT: cond_ok = (n != v);
         COND_GT: cond_ok = ~z & (n == v);
         COND_LE: cond_ok = z | (n != v);
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control FSM with NZCV flag register and memory stall handshake.
// Optional retired-instruction counter enabled by defining MCU_RETIRE_CNT_EN.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int FLAG_W     = 4,
   parameter int ALU_CTRL_W = 4
`ifdef MCU_RETIRE_CNT_EN
  ,parameter int CNT_W      = 32
`endif
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [19:0]           instruction,
   input  logic [FLAG_W-1:0]     alu_flags,
   input  logic                  sh_imm,
   input  logic [1:0]            sh,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  ir_write,
   output logic                  adr_src,
   output logic                  mem_write,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [1:0]            reg_src,
   output logic [1:0]            imm_src,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  sh_src,
   output logic                  mov_src,
   output logic                  mvn_src,
   output logic [FLAG_W-1:0]     flags_q
`ifdef MCU_RETIRE_CNT_EN
  ,output logic [CNT_W-1:0]      retired_cnt
`endif
);

   state_t     state, next_state;
   logic [3:0] cond, cmd;
   logic [1:0] op;
   logic       i_bit, s_bit, cond_ok, flag_en;
   logic       unused_reg_fields;

   assign cond  = instruction[19:16];
   assign op    = instruction[15:14];
   assign i_bit = instruction[13];
   assign cmd   = instruction[12:9];
   assign s_bit = instruction[8];
   assign unused_reg_fields = ^instruction[7:0];

   cond_check u_cond_check (
      .cond    (cond),
      .flags   (flags_q[3:0]),
      .cond_ok (cond_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         flags_q <= '0;
      end else begin
         state <= next_state;
         if (flag_en)
            flags_q <= alu_flags;
      end
   end

   // Every output defaults to 0 so each state only names what it drives
   always_comb begin
      next_state  = state;
      flag_en     = 1'b0;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = RES_ALUOUT;
      reg_src     = 2'b00;
      imm_src     = IMM_DP;
      alu_control = '0;
      sh_src      = 1'b0;
      mov_src     = 1'b0;
      mvn_src     = 1'b0;
      case (state)
         FETCH: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = ALU_CTRL_W'(ALU_ADD);
            result_src  = RES_ALU;
            ir_write    = mem_ready;
            pc_write    = mem_ready;
            if (mem_ready)
               next_state = DECODE;
         end
         DECODE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            reg_src   = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
            imm_src   = (op == 2'b01) ? IMM_MEM : (op == 2'b10) ? IMM_BR : IMM_DP;
            case (op)
               2'b00:   next_state = i_bit ? EXECI : EXECR;
               2'b01:   next_state = MEMADR;
               2'b10:   next_state = BRANCH;
               default: next_state = FETCH;
            endcase
         end
         EXECR, EXECI: begin
            alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
            alu_control = ALU_CTRL_W'(alu_op(cmd));
            sh_src      = ~i_bit & (sh_imm | (sh != 2'b00));
            mov_src     = (cmd == CMD_MOV);
            mvn_src     = (cmd == CMD_MVN);
            flag_en     = s_bit & cond_ok & cmd_supported(cmd);
            next_state  = cmd_is_test(cmd) ? FETCH : ALUWB;
         end
         ALUWB: begin
            reg_write  = cond_ok & cmd_supported(cmd);
            result_src = RES_ALUOUT;
            next_state = FETCH;
         end
         MEMADR: begin
            alu_src_b   = 2'b01;
            imm_src     = IMM_MEM;
            alu_control = ALU_CTRL_W'(ALU_ADD);
            next_state  = s_bit ? MEMRD : MEMWR;
         end
         MEMRD: begin
            adr_src = 1'b1;
            if (mem_ready)
               next_state = MEMWB;
         end
         MEMWB: begin
            reg_write  = cond_ok;
            result_src = RES_MEM;
            next_state = FETCH;
         end
         MEMWR: begin
            adr_src   = 1'b1;
            mem_write = cond_ok;
            if (mem_ready)
               next_state = FETCH;
         end
         BRANCH: begin
            alu_src_b  = 2'b01;
            imm_src    = IMM_BR;
            pc_write   = cond_ok;
            result_src = RES_ALU;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase
   end

`ifdef MCU_RETIRE_CNT_EN
   logic retire;

   // An instruction retires when it leaves for FETCH from a completing state with its condition met
   assign retire = (next_state == FETCH) && cond_ok &&
                   (state inside {ALUWB, MEMWB, MEMWR, BRANCH, EXECR, EXECI});

   always_ff @(posedge clk) begin
      if (reset)
         retired_cnt <= '0;
      else if (retire)
         retired_cnt <= retired_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; control outputs are packed into one vector per cycle.
module tb_multicycle_control_unit;

   logic        clock;
   logic        reset;
   logic [19:0] instruction;
   logic [3:0]  aluFlags;
   logic        shImm;
   logic [1:0]  sh;
   logic        memReady;
   logic        pcWrite, irWrite, adrSrc, memWrite, regWrite, aluSrcA;
   logic [1:0]  aluSrcB, resultSrc, regSrc, immSrc;
   logic [3:0]  aluControl;
   logic        shSrc, movSrc, mvnSrc;
   logic [3:0]  flagsQ;
   logic [9:0]  ctrl;
`ifdef MCU_RETIRE_CNT_EN
   logic [31:0] retiredCnt;
`endif

   int testCount = 0;
   int failCount = 0;

   // Expected control vector {pc,ir,adr,memw,regw,srcA,srcB[1:0],result[1:0]} per state
   localparam logic [9:0] cFetch      = 10'b1100011010;
   localparam logic [9:0] cFetchStall = 10'b0000011010;
   localparam logic [9:0] cDecode     = 10'b0000011000;
   localparam logic [9:0] cExecI      = 10'b0000000100;
   localparam logic [9:0] cExecR      = 10'b0000000000;
   localparam logic [9:0] cAluWb      = 10'b0000100000;
   localparam logic [9:0] cNoWb       = 10'b0000000000;
   localparam logic [9:0] cMemAdr     = 10'b0000000100;
   localparam logic [9:0] cMemRd      = 10'b0010000000;
   localparam logic [9:0] cMemWb      = 10'b0000100001;
   localparam logic [9:0] cMemWr      = 10'b0011000000;
   localparam logic [9:0] cBrTaken    = 10'b1000000110;
   localparam logic [9:0] cBrNot      = 10'b0000000110;

   localparam logic [19:0] iMov   = 20'hE3A01;
   localparam logic [19:0] iCmp   = 20'hE3510;
   localparam logic [19:0] iBeq   = 20'h0A000;
   localparam logic [19:0] iLdr   = 20'hE5912;
   localparam logic [19:0] iStr   = 20'hE5812;
   localparam logic [19:0] iRsb   = 20'hE0611;
   localparam logic [19:0] iAddR  = 20'hE0801;
   localparam logic [19:0] iAndEq = 20'h00100;
   localparam logic [19:0] iMovNv = 20'hF3A01;

   assign ctrl = {pcWrite, irWrite, adrSrc, memWrite, regWrite, aluSrcA, aluSrcB, resultSrc};

   multicycle_control_unit dut (
      .clk         (clock),
      .reset       (reset),
      .instruction (instruction),
      .alu_flags   (aluFlags),
      .sh_imm      (shImm),
      .sh          (sh),
      .mem_ready   (memReady),
      .pc_write    (pcWrite),
      .ir_write    (irWrite),
      .adr_src     (adrSrc),
      .mem_write   (memWrite),
      .reg_write   (regWrite),
      .alu_src_a   (aluSrcA),
      .alu_src_b   (aluSrcB),
      .result_src  (resultSrc),
      .reg_src     (regSrc),
      .imm_src     (immSrc),
      .alu_control (aluControl),
      .sh_src      (shSrc),
      .mov_src     (movSrc),
      .mvn_src     (mvnSrc),
      .flags_q     (flagsQ)
`ifdef MCU_RETIRE_CNT_EN
     ,.retired_cnt (retiredCnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock, then drive this cycle's inputs and let outputs settle
   task automatic applyStimulus(input logic r, input logic [19:0] ins,
                                input logic [3:0] af, input logic mr);
      @(posedge clock);
      #1;
      reset       = r;
      instruction = ins;
      aluFlags    = af;
      memReady    = mr;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1; instruction = iMov; aluFlags = 4'b0000;
      shImm = 1'b0; sh = 2'b00; memReady = 1'b0;

      // Reset state
      applyStimulus(0, iMov, 4'b0000, 0);
      checkOutput("rst_ctrl", ctrl, cFetchStall);
      checkOutput("rst_flags", flagsQ, 4'b0000);

      // MOV immediate: 4 cycles, write-back only in the last
      applyStimulus(0, iMov, 4'b0000, 1); checkOutput("mov_fetch", ctrl, cFetch);
      applyStimulus(0, iMov, 4'b0000, 1); checkOutput("mov_decode", ctrl, cDecode);
      applyStimulus(0, iMov, 4'b0000, 1); checkOutput("mov_exec", ctrl, cExecI);
      checkOutput("mov_src", movSrc, 1'b1);
      applyStimulus(0, iMov, 4'b0000, 1); checkOutput("mov_wb", ctrl, cAluWb);
      applyStimulus(0, iMov, 4'b0000, 1); checkOutput("mov_done", ctrl, cFetch);
      checkOutput("mov_flags", flagsQ, 4'b0000);

      // CMP sets Z, BEQ taken
      applyStimulus(0, iCmp, 4'b0100, 1); checkOutput("cmp_decode", ctrl, cDecode);
      applyStimulus(0, iCmp, 4'b0100, 1); checkOutput("cmp_exec", ctrl, cExecI);
      checkOutput("cmp_aluctl", aluControl, 4'b0001);
      applyStimulus(0, iCmp, 4'b0000, 1); checkOutput("cmp_fetch", ctrl, cFetch);
      checkOutput("cmp_flags", flagsQ, 4'b0100);
      applyStimulus(0, iBeq, 4'b0000, 1); checkOutput("beq_decode", ctrl, cDecode);
      checkOutput("beq_immsrc", immSrc, 2'b10);
      checkOutput("beq_regsrc", regSrc, 2'b01);
      applyStimulus(0, iBeq, 4'b0000, 1); checkOutput("beq_taken", ctrl, cBrTaken);
      applyStimulus(0, iBeq, 4'b0000, 1); checkOutput("beq_back", ctrl, cFetch);

      // CMP clears flags, BEQ not taken
      applyStimulus(0, iCmp, 4'b0000, 1);
      applyStimulus(0, iCmp, 4'b0000, 1);
      applyStimulus(0, iCmp, 4'b0000, 1); checkOutput("cmp0_flags", flagsQ, 4'b0000);
      applyStimulus(0, iBeq, 4'b0000, 1);
      applyStimulus(0, iBeq, 4'b0000, 1); checkOutput("beq_not", ctrl, cBrNot);

      // FETCH stall, then unsupported cmd (RSB): ADD control, no write-back
      applyStimulus(0, iRsb, 4'b0000, 0); checkOutput("fetch_stall", ctrl, cFetchStall);
      applyStimulus(0, iRsb, 4'b0000, 1); checkOutput("fetch_go", ctrl, cFetch);
      applyStimulus(0, iRsb, 4'b0000, 1); checkOutput("rsb_decode", ctrl, cDecode);
      applyStimulus(0, iRsb, 4'b0000, 1); checkOutput("rsb_exec", ctrl, cExecR);
      checkOutput("rsb_aluctl", aluControl, 4'b0000);
      applyStimulus(0, iRsb, 4'b0000, 1); checkOutput("rsb_wb", ctrl, cNoWb);
      applyStimulus(0, iRsb, 4'b0000, 1);

      // Set all flags, then reset during MEMADR
      applyStimulus(0, iCmp, 4'b1111, 1);
      applyStimulus(0, iCmp, 4'b1111, 1);
      applyStimulus(0, iCmp, 4'b1111, 1); checkOutput("flags_all", flagsQ, 4'b1111);
      applyStimulus(0, iLdr, 4'b0000, 1);
      applyStimulus(0, iLdr, 4'b0000, 1); checkOutput("rstmid_memadr", ctrl, cMemAdr);
      applyStimulus(1, iLdr, 4'b0000, 0);
      applyStimulus(0, iLdr, 4'b0000, 0); checkOutput("rstmid_ctrl", ctrl, cFetchStall);
      checkOutput("rstmid_flags", flagsQ, 4'b0000);
      applyStimulus(0, iCmp, 4'b1111, 1);

      // Reset wins over a flag update in EXECI
      applyStimulus(0, iCmp, 4'b1111, 1);
      applyStimulus(0, iCmp, 4'b1111, 1);
      applyStimulus(0, iCmp, 4'b1010, 1); checkOutput("flags_set2", flagsQ, 4'b1111);
      applyStimulus(0, iCmp, 4'b1010, 1);
      applyStimulus(1, iCmp, 4'b1010, 1); checkOutput("rstexec_exec", ctrl, cExecI);
      applyStimulus(0, iCmp, 4'b1010, 0); checkOutput("rstexec_ctrl", ctrl, cFetchStall);
      checkOutput("rstexec_flags", flagsQ, 4'b0000);
      applyStimulus(0, iAndEq, 4'b1111, 1);

      // ANDSEQ with Z clear: no flag update, no write-back
      applyStimulus(0, iAndEq, 4'b1111, 1);
      applyStimulus(0, iAndEq, 4'b1111, 1); checkOutput("andeq_aluctl", aluControl, 4'b0010);
      applyStimulus(0, iAndEq, 4'b1111, 1); checkOutput("andeq_wb", ctrl, cNoWb);
      checkOutput("andeq_flags", flagsQ, 4'b0000);
      applyStimulus(0, iMovNv, 4'b0000, 1);

      // cond=1111 never executes
      applyStimulus(0, iMovNv, 4'b0000, 1);
      applyStimulus(0, iMovNv, 4'b0000, 1);
      applyStimulus(0, iMovNv, 4'b0000, 1); checkOutput("movnv_wb", ctrl, cNoWb);
      applyStimulus(0, iAddR, 4'b0000, 1);

      // Register ADD with LSR shift
      sh = 2'b01;
      applyStimulus(0, iAddR, 4'b0000, 1);
      applyStimulus(0, iAddR, 4'b0000, 1); checkOutput("add_exec", ctrl, cExecR);
      checkOutput("add_shsrc", shSrc, 1'b1);
      checkOutput("add_aluctl", aluControl, 4'b0000);
      applyStimulus(0, iAddR, 4'b0000, 1); checkOutput("add_wb", ctrl, cAluWb);
      sh = 2'b00;
      applyStimulus(0, iLdr, 4'b0000, 1);

      // LDR with two stall cycles in MEMRD: 7 cycles total
      applyStimulus(0, iLdr, 4'b0000, 1);
      applyStimulus(0, iLdr, 4'b0000, 1); checkOutput("ldr_memadr", ctrl, cMemAdr);
      applyStimulus(0, iLdr, 4'b0000, 0); checkOutput("ldr_memrd1", ctrl, cMemRd);
      applyStimulus(0, iLdr, 4'b0000, 0); checkOutput("ldr_memrd2", ctrl, cMemRd);
      applyStimulus(0, iLdr, 4'b0000, 1); checkOutput("ldr_memrd3", ctrl, cMemRd);
      applyStimulus(0, iLdr, 4'b0000, 1); checkOutput("ldr_memwb", ctrl, cMemWb);
      applyStimulus(0, iStr, 4'b0000, 1); checkOutput("ldr_done", ctrl, cFetch);

      // STR
      applyStimulus(0, iStr, 4'b0000, 1); checkOutput("str_decode_regsrc", regSrc, 2'b10);
      applyStimulus(0, iStr, 4'b0000, 1); checkOutput("str_memadr", ctrl, cMemAdr);
      applyStimulus(0, iStr, 4'b0000, 1); checkOutput("str_memwr", ctrl, cMemWr);
      applyStimulus(0, iStr, 4'b0000, 1); checkOutput("str_done", ctrl, cFetch);

`ifdef MCU_RETIRE_CNT_EN
      // ADD, LDR and STR retired since the last reset; ANDEQ and MOVNV failed
      checkOutput("retired_cnt", retiredCnt, 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", testCount, failCount);
      $finish;
   end

endmodule
